fetch_pc_controller: RTL and testbench

//  Sequences the instruction-fetch stage. It owns the architectural fetch PC and drives PC_next/PC_write

---
 rtl/fetch_ctrl_defs.sv | 17 +
 rtl/pc_redirect_sel.sv | 67 ++++++
 rtl/fetch_pc_controller.sv | 119 +++++++++++
 tb/tb_fetch_pc_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_defs.sv
// Shared encodings for the fetch PC controller: FSM states and redirect-select codes.
package fetch_ctrl_defs;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_BRANCH = 2'd3
    } redirect_sel_t;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational priority select of the next fetch PC while running.
// Older instruction wins: EX branch, then ID jump, then halt, then stall, then sequential.
module pc_redirect_sel
    import fetch_ctrl_defs::*;
#(
    parameter int width_B = 32,
    parameter int Addr_B  = 10
) (
    input  logic               active,
    input  logic               branch_taken,
    input  logic [width_B-1:0] branch_target,
    input  logic               jump,
    input  logic [width_B-1:0] jump_target,
    input  logic               halt,
    input  logic               stall,
    input  logic [width_B-1:0] pc_q,
    output redirect_sel_t      sel,
    output logic [width_B-1:0] pc_next,
    output logic               pc_write,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic               halt_hit
);

    localparam logic [width_B-1:0] ADDR_MASK = {{(width_B-Addr_B){1'b0}}, {Addr_B{1'b1}}};
    localparam logic [width_B-1:0] PC_ONE    = {{(width_B-1){1'b0}}, 1'b1};

    function automatic logic [width_B-1:0] rom_addr(input logic [width_B-1:0] v);
        return v & ADDR_MASK;
    endfunction

    // Priority encoder choosing this cycle's single fetch action
    always_comb begin
        sel        = SEL_HOLD;
        pc_next    = pc_q;
        pc_write   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        halt_hit   = 1'b0;
        if (active) begin
            if (branch_taken) begin
                sel        = SEL_BRANCH;
                pc_next    = rom_addr(branch_target);
                pc_write   = 1'b1;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (jump) begin
                sel        = SEL_JUMP;
                pc_next    = rom_addr(jump_target);
                pc_write   = 1'b1;
                flush_ifid = 1'b1;
            end else if (halt) begin
                sel      = SEL_HOLD;
                halt_hit = 1'b1;
            end else if (stall) begin
                sel = SEL_HOLD;
            end else begin
                sel      = SEL_SEQ;
                pc_next  = rom_addr(pc_q + PC_ONE);
                pc_write = 1'b1;
            end
        end else begin
            sel = SEL_HOLD;
        end
    end

endmodule

// File: rtl/fetch_pc_controller.sv
// Fetch-stage sequencer: BOOT/RUN/HALT FSM, architectural fetch PC, boot wait and perf counters.
module fetch_pc_controller
    import fetch_ctrl_defs::*;
#(
    parameter int width_B     = 32,
    parameter int Addr_B      = 10,
    parameter int BOOT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jump,
    input  logic [width_B-1:0] jump_target,
    input  logic               branch_taken,
    input  logic [width_B-1:0] branch_target,
    input  logic               halt,
    output logic [width_B-1:0] PC_next,
    output logic               PC_write,
    output logic               flush_IFID,
    output logic               flush_IDEX,
    output logic               halted,
    output logic [width_B-1:0] fetch_count,
    output logic [width_B-1:0] stall_count
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0]      BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [BW-1:0]      BOOT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [width_B-1:0] CNT_ONE   = {{(width_B-1){1'b0}}, 1'b1};

    fetch_state_t       state_r, state_nxt;
    logic [width_B-1:0] pc_r;
    logic [BW-1:0]      boot_cnt_r;
    logic [width_B-1:0] fetch_cnt_r, stall_cnt_r;

    logic               run_s;
    redirect_sel_t      sel_s;
    logic [width_B-1:0] sel_pc_s;
    logic               sel_write_s, sel_fifid_s, sel_fidex_s, halt_hit_s;
    logic               stall_cycle_s;

    assign run_s         = (state_r == ST_RUN) && !reset;
    assign stall_cycle_s = run_s && (sel_s == SEL_HOLD) && !halt_hit_s;

    pc_redirect_sel #(
        .width_B(width_B),
        .Addr_B (Addr_B)
    ) u_sel (
        .active       (run_s),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .halt         (halt),
        .stall        (stall),
        .pc_q         (pc_r),
        .sel          (sel_s),
        .pc_next      (sel_pc_s),
        .pc_write     (sel_write_s),
        .flush_ifid   (sel_fifid_s),
        .flush_idex   (sel_fidex_s),
        .halt_hit     (halt_hit_s)
    );

    // Next-state and fetch-block outputs; reset forces a quiet, zero-PC cycle
    always_comb begin
        state_nxt  = state_r;
        PC_next    = pc_r;
        PC_write   = 1'b0;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        halted     = 1'b0;
        if (reset) begin
            state_nxt = ST_BOOT;
            PC_next   = '0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    if (boot_cnt_r == BOOT_LAST) state_nxt = ST_RUN;
                    else                         state_nxt = ST_BOOT;
                end
                ST_RUN: begin
                    PC_next    = sel_pc_s;
                    PC_write   = sel_write_s;
                    flush_IFID = sel_fifid_s;
                    flush_IDEX = sel_fidex_s;
                    if (halt_hit_s) state_nxt = ST_HALT;
                    else            state_nxt = ST_RUN;
                end
                ST_HALT: begin
                    halted    = 1'b1;
                    state_nxt = ST_HALT;
                end
                default: state_nxt = ST_BOOT;
            endcase
        end
    end

    // State, PC, boot wait and performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_BOOT;
            pc_r        <= '0;
            boot_cnt_r  <= '0;
            fetch_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            state_r <= state_nxt;
            if (PC_write) pc_r <= PC_next;
            if (state_r == ST_BOOT) boot_cnt_r <= boot_cnt_r + BOOT_ONE;
            if (run_s && PC_write) fetch_cnt_r <= fetch_cnt_r + CNT_ONE;
            if (stall_cycle_s) stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end
    end

    assign fetch_count = fetch_cnt_r;
    assign stall_count = stall_cnt_r;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_fetch_pc_controller;

    localparam int W = 32;
    localparam int BOOT = 2;
    localparam logic [31:0] ROM = 32'd1024;

    logic        clk = 1'b0;
    logic        reset, stall, jump, branch_taken, halt;
    logic [31:0] jump_target, branch_target;
    logic [31:0] PC_next, fetch_count, stall_count;
    logic        PC_write, flush_IFID, flush_IDEX, halted;

    fetch_pc_controller #(.width_B(W), .Addr_B(10), .BOOT_CYCLES(BOOT)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
        .PC_next(PC_next), .PC_write(PC_write), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .halted(halted), .fetch_count(fetch_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        wr;
        logic        fi;
        logic        fe;
        logic        hl;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state: mode 0=boot 1=run 2=halt
    int          m_mode;
    int          m_boot_seen;
    logic [31:0] m_pc, m_fc, m_sc;

    task automatic model_reset();
        m_mode = 0; m_boot_seen = 0; m_pc = 32'd0; m_fc = 32'd0; m_sc = 32'd0;
    endtask

    task automatic cyc(input logic r, input logic st, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input logic h);
        exp_t e;
        reset = r; stall = st; jump = j; jump_target = jt;
        branch_taken = b; branch_target = bt; halt = h;
        e.pc = m_pc; e.wr = 1'b0; e.fi = 1'b0; e.fe = 1'b0; e.hl = 1'b0;
        e.fc = m_fc; e.sc = m_sc;
        if (r) begin
            e.pc = 32'd0;
            exp_q.push_back(e);
            model_reset();
        end else if (m_mode == 0) begin
            exp_q.push_back(e);
            m_boot_seen++;
            if (m_boot_seen == BOOT) m_mode = 1;
        end else if (m_mode == 2) begin
            e.hl = 1'b1;
            exp_q.push_back(e);
        end else begin
            if (b) begin
                e.pc = bt % ROM; e.wr = 1'b1; e.fi = 1'b1; e.fe = 1'b1;
            end else if (j) begin
                e.pc = jt % ROM; e.wr = 1'b1; e.fi = 1'b1;
            end else if (h) begin
                m_mode = 2;
            end else if (st) begin
                m_sc = m_sc + 32'd1;
            end else begin
                e.pc = (m_pc + 32'd1) % ROM; e.wr = 1'b1;
            end
            exp_q.push_back(e);
            if (e.wr) begin
                m_pc = e.pc;
                m_fc = m_fc + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    // monitor: the DUT presents a response every cycle; compare at negedge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (PC_next !== e.pc || PC_write !== e.wr || flush_IFID !== e.fi || flush_IDEX !== e.fe ||
                halted !== e.hl || fetch_count !== e.fc || stall_count !== e.sc) begin
                errors++;
                $display("FAIL cycle_out t=%0t got pc=%h wr=%b fi=%b fe=%b hl=%b fc=%0d sc=%0d want pc=%h wr=%b fi=%b fe=%b hl=%b fc=%0d sc=%0d",
                         $time, PC_next, PC_write, flush_IFID, flush_IDEX, halted, fetch_count, stall_count,
                         e.pc, e.wr, e.fi, e.fe, e.hl, e.fc, e.sc);
            end
        end
    end

    initial begin
        int wait_cnt;
        reset = 1'b1; stall = 1'b0; jump = 1'b0; halt = 1'b0; branch_taken = 1'b0;
        jump_target = 32'd0; branch_target = 32'd0;
        model_reset();
        @(posedge clk);
        #1;
        // reset, boot, sequential run up to pc 5
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle(7);
        // stall held three cycles
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle(1);
        // branch beats jump and stall
        cyc(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0);
        idle(2);
        // truncation and wrap
        cyc(1'b0, 1'b0, 1'b1, 32'h1234, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3FE, 1'b0, 32'd0, 1'b0);
        idle(3);
        // halt alone, then hammered by inputs
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom));
        // reset mid-run at pc 0x20
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 32'h1F, 1'b0, 32'd0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle(3);
        // halt together with branch: branch wins, no halt
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h155, 1'b1);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0), $urandom,
                ($urandom_range(7) == 0), $urandom, ($urandom_range(47) == 0));
        end
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
